// File: rtl/l2_reg_serializer.sv
// -----------------------------------------------------------------------------
// l2_reg_serializer
//
// Purpose:
//   Transmit-side counterpart of the 12-byte L2 register splice. A 96-bit word
//   is captured on load and then emitted as NBYTES byte writes (dout, Sel, We).
//   These feed the splice din/Sel/We inputs directly. A valid/ready handshake
//   on the byte side lets the sink stall the transfer.
//
// Handshake:
//   We is "valid" and out_ready is "ready". A byte transfers on a rising edge
//   where We & out_ready. While We=1 and out_ready=0, dout, Sel and We hold.
//   On the word side, load is accepted only on an edge where in_ready=1.
//
// Ports:
//   clk        in   clock; all logic is on the rising edge
//   rst        in   synchronous, active-high reset
//   din        in   word to send; byte k = din[k*BYTE_W +: BYTE_W]
//   load       in   start a word (accepted only when in_ready=1)
//   in_ready   out  idle, can accept load
//   abort      in   cancel the word in flight (no done pulse)
//   dout       out  current byte (0 whenever We=0)
//   Sel        out  true byte position of dout
//   We         out  byte valid / write strobe
//   out_ready  in   sink accepts the byte this cycle
//   done       out  one-cycle pulse after the last byte is accepted
//
// Configuration:
//   L2_SER_MSB_FIRST_EN  undefined: send byte 0 first (Sel 0 .. NBYTES-1)
//                        defined:   send byte NBYTES-1 first (Sel NBYTES-1 .. 0)
// -----------------------------------------------------------------------------
module l2_reg_serializer #(
    parameter int NBYTES = 12,
    parameter int BYTE_W = 8,
    parameter int SEL_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NBYTES*BYTE_W-1:0] din,
    input  logic                     load,
    output logic                     in_ready,
    input  logic                     abort,
    output logic [BYTE_W-1:0]        dout,
    output logic [SEL_W-1:0]         Sel,
    output logic                     We,
    input  logic                     out_ready,
    output logic                     done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // First and last byte position in send order. Sel always names the true
    // byte position, so only the traversal direction changes.
`ifdef L2_SER_MSB_FIRST_EN
    localparam logic [SEL_W-1:0] FIRST_IDX = SEL_W'(NBYTES - 1);
    localparam logic [SEL_W-1:0] LAST_IDX  = '0;
`else
    localparam logic [SEL_W-1:0] FIRST_IDX = '0;
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NBYTES - 1);
`endif

    state_t                   r_state;
    state_t                   w_next_state;
    logic [NBYTES*BYTE_W-1:0] r_shadow;
    logic [SEL_W-1:0]         r_idx;
    logic                     r_done;

    logic                     w_xfer;
    logic                     w_last;
    logic [SEL_W-1:0]         w_idx_step;

    assign w_xfer = (r_state == ST_SEND) && out_ready;
    assign w_last = (r_idx == LAST_IDX);

`ifdef L2_SER_MSB_FIRST_EN
    assign w_idx_step = r_idx - SEL_W'(1);
`else
    assign w_idx_step = r_idx + SEL_W'(1);
`endif

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // abort is ignored in IDLE, so abort together with load lets load win.
    // ---------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_xfer && w_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers: shadow word, byte index, done pulse.
    // The index parks at 0 whenever the block goes idle, so Sel reads 0
    // in IDLE in both send orders.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_idx    <= '0;
            r_done   <= 1'b0;
        end else begin
            // abort beats a simultaneous last transfer: the byte is taken by
            // the sink, but the word is not reported as complete.
            r_done <= w_xfer && w_last && !abort;

            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_shadow <= din;
                        r_idx    <= FIRST_IDX;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        r_idx <= '0;
                    end else if (w_xfer) begin
                        if (w_last) begin
                            r_idx <= '0;
                        end else begin
                            r_idx <= w_idx_step;
                        end
                    end
                end
                default: r_idx <= '0;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        in_ready = (r_state == ST_IDLE);
        We       = (r_state == ST_SEND);
        Sel      = r_idx;
        done     = r_done;
        dout     = '0;
        if (r_state == ST_SEND) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (r_idx == SEL_W'(k)) begin
                    dout = r_shadow[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

endmodule
